demux1x2_4b_reg: RTL and testbench

Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the receive-side counterpart of the 4-bit 2:1 mux in the 32-bit ALU datapath. One input word stream is steered by `select` into one of two independently back-pressured output slots. Each output keeps a count of the words it has delivered, which lets ALU operand-distribution logic fan one bus out to two consumers without losing words.

---
 rtl/demux1x2_4b_reg_slot.sv | 48 ++++
 rtl/demux1x2_4b_reg.sv | 54 +++++
 tb/tb_demux1x2_4b_reg.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/demux1x2_4b_reg_slot.sv
// One-entry output slot: holding register, EMPTY/FULL state and a delivered-word counter.
// Loads appear one cycle later; a full slot reloads on the same edge its word is taken.
module demux_slot #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             can_load
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic state;
  logic out_xfer;
  logic in_xfer;

  assign valid    = (state == FULL);
  assign can_load = !valid || take;
  assign out_xfer = valid && take;
  assign in_xfer  = load && can_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      data  <= '0;
      cnt   <= '0;
    end else begin
      if (out_xfer)
        cnt <= cnt + 1'b1;
      // A reload in the same cycle as a take keeps the slot FULL.
      if (in_xfer) begin
        state <= FULL;
        data  <= load_data;
      end else if (out_xfer) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: rtl/demux1x2_4b_reg.sv
// Registered 1:2 demux: select steers each input word into one of two independently
// back-pressured slots with one-cycle latency; in_ready reflects only the selected slot.
module demux1x2_4b_reg #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             select,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic load0, load1;
  logic can_load0, can_load1;

  assign load0    = in_valid && !select;
  assign load1    = in_valid &&  select;
  assign in_ready = !reset && (select ? can_load1 : can_load0);

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0),
    .load_data (in_data),
    .take      (out0_ready),
    .data      (out0_data),
    .valid     (out0_valid),
    .cnt       (cnt0),
    .can_load  (can_load0)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1),
    .load_data (in_data),
    .take      (out1_ready),
    .data      (out1_data),
    .valid     (out1_valid),
    .cnt       (cnt1),
    .can_load  (can_load1)
  );

endmodule

// File: tb/tb_demux1x2_4b_reg.sv
// Bench for demux1x2_4b_reg: directed scenarios plus random traffic against a slot-level model;
// a second instance with 2-bit counters shares the stimulus to exercise counter wrap.
module tb_demux1x2_4b_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       select;
  logic       out0_ready;
  logic       out1_ready;

  logic       in_ready,  w_in_ready;
  logic [3:0] out0_data, out1_data, w_out0_data, w_out1_data;
  logic       out0_valid, out1_valid, w_out0_valid, w_out1_valid;
  logic [7:0] cnt0, cnt1;
  logic [1:0] w_cnt0, w_cnt1;

  int errors = 0;
  int checks = 0;

  // Reference state: per-slot fullness, held word and total words delivered.
  bit m_vld [2];
  int m_dat [2];
  int m_cnt [2];

  always #5 clk = ~clk;

  demux1x2_4b_reg dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  demux1x2_4b_reg #(.WIDTH(4), .CNT_W(2)) dut_w (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(w_in_ready),
    .select(select), .out0_data(w_out0_data), .out0_valid(w_out0_valid), .out0_ready(out0_ready),
    .out1_data(w_out1_data), .out1_valid(w_out1_valid), .out1_ready(out1_ready),
    .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_ready();
    int s;
    s = int'(select);
    return {31'd0, !reset && (!m_vld[s] || (s == 0 ? out0_ready : out1_ready))};
  endfunction

  // Apply one cycle of stimulus, check the handshake, clock it, update the model, check outputs.
  task automatic cyc(input bit rst, input bit iv, input bit sel, input int din,
                     input bit r0, input bit r1);
    bit rdy[2];
    bit acc;
    reset = rst; in_valid = iv; select = sel; in_data = 4'(din);
    out0_ready = r0; out1_ready = r1;
    #1;
    check("in_ready",   32'(in_ready),   exp_ready());
    check("w_in_ready", 32'(w_in_ready), exp_ready());
    acc = !rst && iv && (!m_vld[sel] || (sel ? r1 : r0));
    rdy[0] = r0; rdy[1] = r1;
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (rst) begin
        m_vld[n] = 0; m_dat[n] = 0; m_cnt[n] = 0;
      end else begin
        if (m_vld[n] && rdy[n]) begin
          m_cnt[n]++;
          m_vld[n] = 0;
        end
        if (acc && int'(sel) == n) begin
          m_vld[n] = 1;
          m_dat[n] = din % 16;
        end
      end
    end
    #1;
    check("out0_valid", 32'(out0_valid), 32'(m_vld[0]));
    check("out1_valid", 32'(out1_valid), 32'(m_vld[1]));
    check("out0_data",  32'(out0_data),  32'(m_dat[0]));
    check("out1_data",  32'(out1_data),  32'(m_dat[1]));
    check("cnt0",       32'(cnt0),       32'(m_cnt[0] % 256));
    check("cnt1",       32'(cnt1),       32'(m_cnt[1] % 256));
    check("w_cnt0",     32'(w_cnt0),     32'(m_cnt[0] % 4));
    check("w_cnt1",     32'(w_cnt1),     32'(m_cnt[1] % 4));
    check("w_out0_data", 32'(w_out0_data), 32'(m_dat[0]));
    check("w_out1_valid", 32'(w_out1_valid), 32'(m_vld[1]));
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      m_vld[n] = 0; m_dat[n] = 0; m_cnt[n] = 0;
    end
    reset = 1'b1; in_valid = 1'b0; select = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles with traffic offered: nothing loads.
    cyc(1, 1, 0, 4'hA, 1, 1);
    cyc(1, 1, 1, 4'h5, 1, 1);
    check("rst_in_ready_low", 32'(in_ready), 32'd0);

    // Routing to each slot.
    cyc(0, 1, 0, 4'b1010, 0, 0);
    check("route0_data", 32'(out0_data), 32'd10);
    cyc(0, 1, 1, 4'b0010, 0, 0);
    check("route1_keep0", 32'(out0_data), 32'd10);

    // Back-pressure, then release with pass-through reload.
    cyc(0, 1, 0, 4'b0001, 0, 0);
    check("bp_hold", 32'(out0_data), 32'd10);
    cyc(0, 1, 0, 4'b0001, 1, 0);
    check("bp_cnt0", 32'(cnt0), 32'd1);
    check("bp_reload", 32'(out0_data), 32'd1);

    // Drain, then stream 8 words to slot 1.
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1, i, 0, 1);
      check("stream_data", 32'(out1_data), 32'(i));
    end
    cyc(0, 0, 1, 0, 0, 1);
    check("stream_cnt1", 32'(cnt1), 32'd9);

    // Alternating select at full rate, then long slot-0 stream to wrap the 8-bit counter.
    for (int i = 0; i < 16; i++) cyc(0, 1, i[0], i, 1, 1);
    for (int i = 0; i < 260; i++) cyc(0, 1, 0, i, 1, $urandom_range(0, 1));

    // Reset with both slots full.
    cyc(0, 1, 0, 4'b0110, 0, 0);
    cyc(0, 1, 1, 4'b0111, 0, 0);
    cyc(1, 1, 0, 4'b1111, 1, 1);
    check("mid_rst_cnt0", 32'(cnt0), 32'd0);
    cyc(0, 1, 1, 4'b1000, 0, 0);
    check("post_rst_data", 32'(out1_data), 32'd8);
    check("post_rst_cnt1", 32'(cnt1), 32'd0);

    // Random traffic with occasional reset.
    for (int i = 0; i < 500; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
          int'($urandom_range(0, 15)), $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
